// File: rtl/bcomp_mc_pkg.sv
// rtl/bcomp_mc_pkg.sv - shared state encoding and widths for bcomp_mc
package bcomp_mc_pkg;

  localparam int X_W  = 18;
  localparam int Y_W  = 39;
  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,  S4  = 4'd4,
    S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,  S8  = 4'd8,
    S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11, S12 = 4'd12,
    S13 = 4'd13, S14 = 4'd14
  } state_t;

  function automatic logic is_legal(input logic [ST_W-1:0] s);
    return (s >= 4'd1) && (s <= 4'd14);
  endfunction

endpackage

// File: rtl/bcomp_mc_ch.sv
// rtl/bcomp_mc_ch.sv - one bcomp_mc channel: state register, Mealy decode, saturating done counter
module bcomp_mc_ch
  import bcomp_mc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [X_W-1:0]   i_x,
  input  logic             i_hold,
  input  logic             i_key_ok,
  output logic [Y_W-1:0]   o_y,
  output logic [CNT_W-1:0] o_done_cnt,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_nxt;
  state_t           w_d_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [X_W:1]     w_x;
  logic [Y_W:1]     w_y;
  logic [Y_W:1]     w_d_y;
  logic             w_f;
  logic             w_t;
  logic             w_inc;
  logic [2:0]       w_idx;

  // 1-based views so the decode reads like the control table
  assign w_x   = i_x;
  assign w_f   = w_x[14] & (w_x[10] | w_x[11]);
  assign w_t   = w_x[8] ? (w_x[9] ? ~w_x[16] : w_x[17]) : (w_x[9] ? w_x[18] : ~w_x[18]);
  assign w_idx = {w_x[7], w_x[8], w_x[9]};

  // Dispatch D is shared by S8 and the ~x6&~x3 arm of S6
  always_comb begin
    w_d_y   = '0;
    w_d_nxt = S7;
    if (w_x[12]) begin
      if (w_x[4]) begin
        {w_d_y[1], w_d_y[5], w_d_y[8]} = 3'b111;
        w_d_nxt = S9;
      end else if (w_x[5]) begin
        {w_d_y[2], w_d_y[14], w_d_y[15]} = 3'b111;
        w_d_nxt = S10;
      end else begin
        {w_d_y[1], w_d_y[2], w_d_y[16]} = 3'b111;
        w_d_nxt = S7;
      end
    end else if (w_x[4]) begin
      if (w_x[5]) begin
        {w_d_y[1], w_d_y[3], w_d_y[14]} = 3'b111;
        w_d_nxt = S7;
      end else begin
        {w_d_y[1], w_d_y[5], w_d_y[8]} = 3'b111;
        w_d_nxt = S11;
      end
    end else begin
      {w_d_y[1], w_d_y[5], w_d_y[8]} = 3'b111;
      w_d_nxt = S12;
    end
  end

  always_comb begin
    w_y   = '0;
    w_nxt = r_state;
    case (r_state)
      S1: begin
        if (w_x[1] && i_key_ok) begin
          w_y[2] = 1'b1;
          if (w_x[2]) begin
            {w_y[36], w_y[37]} = 2'b11;
            w_nxt = S2;
          end else begin
            w_y[4] = 1'b1;
            w_nxt  = S3;
          end
        end
      end
      S2: begin
        {w_y[1], w_y[2], w_y[3], w_y[14], w_y[38]} = 5'b11111;
        w_nxt = S4;
      end
      S3: begin
        {w_y[1], w_y[5], w_y[6], w_y[7]} = 4'b1111;
        w_nxt = S5;
      end
      S4: begin
        {w_y[7], w_y[10], w_y[23]} = 3'b111;
        w_nxt = S1;
      end
      S5: begin
        {w_y[2], w_y[3], w_y[4]} = 3'b111;
        w_nxt = S6;
      end
      S6: begin
        if (w_x[6] && w_x[3]) begin
          if (w_x[7]) begin
            if (w_x[9]) w_y[23] = 1'b1;
            else        w_y[22] = 1'b1;
            w_nxt = S7;
          end else if (w_x[8]) begin
            if ((w_x[9] && w_x[11]) || (!w_x[9] && w_x[10])) begin
              w_y[7] = 1'b1;
              w_nxt  = S7;
            end else begin
              w_y[35] = w_f;
              w_nxt   = S1;
            end
          end else begin
            if (w_x[9]) {w_y[20], w_y[21]} = 2'b11;
            else        {w_y[18], w_y[19]} = 2'b11;
            w_nxt = S7;
          end
        end else if (w_x[6]) begin
          if (w_x[15]) begin
            if (w_t) begin
              w_y[7] = 1'b1;
              w_nxt  = S7;
            end else begin
              w_y[35] = w_f;
              w_nxt   = S1;
            end
          end else begin
            case (w_idx)
              3'd7:    w_y[34] = 1'b1;
              3'd6:    w_y[33] = 1'b1;
              3'd5:    w_y[39] = 1'b1;
              3'd4:    w_y[32] = 1'b1;
              3'd3:    {w_y[29], w_y[30], w_y[31]} = 3'b111;
              3'd2:    {w_y[26], w_y[27], w_y[28]} = 3'b111;
              3'd1:    w_y[25] = 1'b1;
              default: w_y[24] = 1'b1;
            endcase
            w_nxt = S7;
          end
        end else if (w_x[3]) begin
          {w_y[1], w_y[4], w_y[5]} = 3'b111;
          w_nxt = S8;
        end else begin
          w_y   = w_d_y;
          w_nxt = w_d_nxt;
        end
      end
      S7: begin
        w_y[35] = w_f;
        w_nxt   = S1;
      end
      S8: begin
        w_y   = w_d_y;
        w_nxt = w_d_nxt;
      end
      S9: begin
        w_y[17] = 1'b1;
        w_nxt   = S13;
      end
      S10: begin
        {w_y[1], w_y[2], w_y[16]} = 3'b111;
        w_nxt = S7;
      end
      S11: begin
        {w_y[3], w_y[13]} = 2'b11;
        w_nxt = S7;
      end
      S12: begin
        if (w_x[5]) {w_y[11], w_y[12]} = 2'b11;
        else        w_y[9] = 1'b1;
        w_nxt = S7;
      end
      S13: begin
        {w_y[3], w_y[14]} = 2'b11;
        w_nxt = S14;
      end
      S14: begin
        if (w_x[13]) begin
          w_y[7] = 1'b1;
          w_nxt  = S7;
        end else begin
          w_y[35] = w_f;
          w_nxt   = S1;
        end
      end
      default: begin
        w_y   = '0;
        w_nxt = S1;
      end
    endcase
  end

  // Recovery from an illegal code lands in S1 but is not a completed operation
  assign w_inc = (w_nxt == S1) && (r_state != S1) && is_legal(r_state) &&
                 (r_cnt != {CNT_W{1'b1}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S1;
      r_cnt   <= '0;
    end else if (!i_hold) begin
      r_state <= w_nxt;
      if (w_inc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_y        = i_hold ? '0 : w_y;
  assign o_done_cnt = r_cnt;
  assign o_busy     = (r_state != S1);

endmodule

// File: rtl/bcomp_mc.sv
// rtl/bcomp_mc.sv - NCH-channel compare/branch micro-op controller; BCOMP_MC_LOCK_EN adds key-gated start
module bcomp_mc
  import bcomp_mc_pkg::*;
#(
  parameter int               NCH     = 2,
  parameter int               CNT_W   = 8,
  parameter int               KEY_W   = 16,
  parameter logic [KEY_W-1:0] KEY_VAL = 16'hA5C3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*X_W-1:0]   x,
  input  logic [NCH-1:0]       hold,
`ifdef BCOMP_MC_LOCK_EN
  input  logic [KEY_W-1:0]     key,
`endif
  output logic [NCH*Y_W-1:0]   y,
  output logic [NCH*CNT_W-1:0] done_cnt,
  output logic [NCH-1:0]       busy
);

  logic w_key_ok;

`ifdef BCOMP_MC_LOCK_EN
  assign w_key_ok = (key == KEY_VAL);
`else
  // Key parameters have no function without the lock
  logic [KEY_W-1:0] w_unused_key;
  assign w_unused_key = KEY_VAL;
  assign w_key_ok     = 1'b1;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    bcomp_mc_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_x        (x[c*X_W +: X_W]),
      .i_hold     (hold[c]),
      .i_key_ok   (w_key_ok),
      .o_y        (y[c*Y_W +: Y_W]),
      .o_done_cnt (done_cnt[c*CNT_W +: CNT_W]),
      .o_busy     (busy[c])
    );
  end

endmodule

// File: doc/bcomp_mc.md
# bcomp_mc

Multi-channel, parametrised compare/branch micro-op controller for the small-FSM benchmark suite. It holds NCH independent copies of one 14-state control table. Each copy maps an 18-bit condition vector to a 39-bit one-hot-group micro-op vector. Over the single-channel form it adds per-channel stall, per-channel completed-operation counters, a safe recovery path for illegal state codes, and an optional key-gated start.

## Interface
- NCH, 2: number of independent channels (1..8)
- CNT_W, 8: width of each completed-operation counter
- KEY_W, 16: key width (used only with lock enabled)
- KEY_VAL, 16'hA5C3: accepted key value (used only with lock enabled)
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- x  in  NCH*18  condition inputs; channel c uses bits [18c+17:18c]; local bit i-1 is xi
- hold  in  NCH  per-channel stall
- key  in  KEY_W  start key (present only with lock enabled)
- y  out  NCH*39  micro-op outputs; local bit i-1 is yi
- done_cnt  out  NCH*CNT_W  per-channel count of returns to S1
- busy  out  NCH  high when the channel state is not S1

## Operation
- Per channel: 4-bit state S1..S14 is encoded 1..14. Outputs are Mealy (combinational from state and x). All y bits default to 0.
- Shorthand used below:
  - F = x14&(x10|x11).
  - FIN means: set y35=F, go to S1.
- S1:
  - x1&x2: y2,y36,y37, go to S2.
  - x1&~x2: y2,y4, go to S3.
  - ~x1: stay in S1.
- Fixed single-cycle steps:
  - S2: y1,y2,y3,y14,y38, go to S4.
  - S3: y1,y5,y6,y7, go to S5.
  - S4: y7,y10,y23, go to S1.
  - S5: y2,y3,y4, go to S6.
  - S9: y17, go to S13.
  - S10: y1,y2,y16, go to S7.
  - S11: y3,y13, go to S7.
  - S13: y3,y14, go to S14.
- S6 decode:
  - x6&x3&x7: (x9 ? y23 : y22), go to S7.
  - x6&x3&~x7&x8:
    - (x9&x11)|(~x9&x10): y7, go to S7.
    - otherwise FIN.
  - x6&x3&~x7&~x8: (x9 ? y20,y21 : y18,y19), go to S7.
  - x6&~x3&x15: test T = x8 ? (x9 ? ~x16 : x17) : (x9 ? x18 : ~x18).
    - T: y7, go to S7.
    - otherwise FIN.
  - x6&~x3&~x15: index {x7,x8,x9}, then go to S7.
    - 7: y34. 6: y33. 5: y39. 4: y32.
    - 3: y29,y30,y31. 2: y26,y27,y28.
    - 1: y25. 0: y24.
  - ~x6&x3: y1,y4,y5, go to S8.
  - ~x6&~x3: dispatch D (below), taken directly from S6.
- S8: dispatch D.
  - x12&x4: y1,y5,y8, go to S9.
  - x12&~x4&x5: y2,y14,y15, go to S10.
  - x12&~x4&~x5: y1,y2,y16, go to S7.
  - ~x12&x4&x5: y1,y3,y14, go to S7.
  - ~x12&x4&~x5: y1,y5,y8, go to S11.
  - ~x12&~x4: y1,y5,y8, go to S12.
- S12: (x5 ? y11,y12 : y9), go to S7.
- S7: FIN.
- S14: x13 gives y7 and goes to S7; otherwise FIN.
- Illegal state code 0 or 15: y=0, go to S1. done_cnt does not increment.
- hold[c]=1: y for channel c forced to 0, state and counter frozen. Other channels are unaffected.
- done_cnt[c] increments on every taken transition into S1 from any state other than S1. It saturates at 2^CNT_W-1.
- busy[c] = (state != S1).

## Timing
- State and counters update on the rising clk edge. y is valid in the same cycle as the state and x.
- Latency, S1 to S1 (no hold):
  - x1&x2 path: 3 cycles (S1→S2→S4→S1).
  - Shortest x1&~x2 path: 4 cycles (S1→S3→S5→S6→S1 via FIN).
- Reset (asynchronous, any time including mid-operation):
  - all states go to S1
  - done_cnt = 0
  - busy = 0
  - y is 0 unless x1=1 in that channel (Mealy output from S1)
- Hold takes precedence over the next-state logic. Hold asserted in the same cycle as a transition into S1 blocks both the transition and the counter increment.

## Configuration
- BCOMP_MC_LOCK_EN defined:
  - key port exists.
  - S1 leaves only when key==KEY_VAL. On a mismatch the channel stays in S1 with y=0.
  - key is ignored in all states other than S1.
- Undefined: no key port; S1 behaves as in Operation.

## Structure
- Shared package bcomp_mc_pkg holds:
  - state enum (S1=1 … S14=14)
  - width constants X_W=18, Y_W=39, ST_W=4
- Sub-module bcomp_mc_ch: one channel (state register, decode, counter). The top generates NCH instances and passes key-match as a 1-bit input.

## Test plan
- Reset, then x1=1,x2=1 on channel 0:
  - y shows bits {2,36,37}, then {1,2,3,14,38}, then {7,10,23}.
  - done_cnt0 = 1 after 3 cycles.
  - channel 1 is idle, with done_cnt1 = 0.
- Path S3→S5→S6 with x6=1,x3=0,x15=0,x7=1,x8=0,x9=1: y39 in S6, then in S7 x14=1,x10=1 gives y35, then S1.
- S6 with x6=0,x3=0,x12=1,x4=1: y{1,5,8}, then S9 y17, then S13 y{3,14}. S14 with x13=0,x14=0: S1, y35=0.
- hold=1 for 5 cycles while in S5: state, counter and y=0 are frozen. On release, S6 is entered on the next edge.
- done_cnt with CNT_W=2 after 5 completed operations: reads 3.
- With BCOMP_MC_LOCK_EN:
  - key=16'h0000 and x1=1: stays in S1 with y=0.
  - key=16'hA5C3: enters S2.
  - rst pulsed while in S12: S1 and done_cnt=0 immediately, asynchronously.
